nios_fprint_processorm_0_cpu0_dct_packer: RTL and testbench

Producer side of the OCI data-compression-trace (DCT) path. It accepts 2-bit trace symbols from the CPU trace logic and packs them into a 30-bit buffer with a 4-bit fill count, exposing the same `dct_buffer`/`dct_count` pair the OCI test bench monitors. Completed or flushed words are sealed into a single-entry output slot. The slot drains to the trace FIFO over a valid/ready handshake.

---
 rtl/nios_fprint_processorm_0_cpu0_dct_packer_pkg.sv | 22 ++
 rtl/nios_fprint_processorm_0_cpu0_dct_packer_if.sv | 28 ++
 rtl/nios_fprint_processorm_0_cpu0_dct_packer_out_slot.sv | 41 ++++
 rtl/nios_fprint_processorm_0_cpu0_dct_packer.sv | 101 ++++++++++
 tb/tb_nios_fprint_processorm_0_cpu0_dct_packer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/nios_fprint_processorm_0_cpu0_dct_packer_pkg.sv
// Shared sizes, types and FSM encoding for the OCI DCT trace packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_fprint_dct_pkg;

    localparam int SYMBOL_W = 2;                  // bits per trace symbol
    localparam int SLOTS    = 15;                 // symbols per packed word
    localparam int COUNT_W  = 4;                  // must be able to hold SLOTS
    localparam int BUF_W    = SYMBOL_W * SLOTS;   // 30-bit packed word

    typedef logic [SYMBOL_W-1:0] dct_sym_t;
    typedef logic [BUF_W-1:0]    dct_buf_t;
    typedef logic [COUNT_W-1:0]  dct_cnt_t;

    // IDLE: empty accumulator; ACCUM: 1..14 symbols; STALL: waiting on the slot
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } dct_state_t;

endpackage

// File: rtl/nios_fprint_processorm_0_cpu0_dct_packer_if.sv
// Symbol-in / word-out handshake bundle for the DCT packer.
// Latency: n/a (wiring only).
// Backpressure: sym_ready toward the trace logic, word_ready from the trace FIFO.
interface nios_fprint_processorm_0_cpu0_dct_packer_if;
    import nios_fprint_dct_pkg::*;

    logic     sym_valid;
    dct_sym_t sym_data;
    logic     sym_ready;
    logic     flush;
    logic     word_valid;
    dct_buf_t word_data;
    dct_cnt_t word_count;
    logic     word_ready;

    // Trace logic / trace FIFO side: offers symbols, consumes words
    modport master (
        output sym_valid, sym_data, flush, word_ready,
        input  sym_ready, word_valid, word_data, word_count
    );

    // Packer side: accepts symbols, produces words
    modport slave (
        input  sym_valid, sym_data, flush, word_ready,
        output sym_ready, word_valid, word_data, word_count
    );

endinterface

// File: rtl/nios_fprint_processorm_0_cpu0_dct_packer_out_slot.sv
// Single-entry valid/ready holding register for sealed DCT words.
// Latency: load at edge N is visible at N+1.
// Backpressure: holds the word while ready is low; load with drain refills in one edge.
module nios_fprint_dct_out_slot
    import nios_fprint_dct_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_load,
    input  dct_buf_t i_data,
    input  dct_cnt_t i_count,
    input  logic     i_ready,
    output logic     o_valid,
    output dct_buf_t o_data,
    output dct_cnt_t o_count
);

    logic     r_valid;
    dct_buf_t r_data;
    dct_cnt_t r_count;

    // Load wins over drain so a same-edge refill keeps valid high with new data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_count <= i_count;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: rtl/nios_fprint_processorm_0_cpu0_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit words (first symbol highest) and seals full/flushed words.
// Latency: accept at N updates dct_buffer/count at N+1; a seal at N shows word_valid at N+1.
// Backpressure: sym_ready drops only in STALL (word waiting for a busy output slot).
module nios_fprint_processorm_0_cpu0_dct_packer
    import nios_fprint_dct_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    nios_fprint_processorm_0_cpu0_dct_packer_if.slave dct,
    output dct_buf_t o_dct_buffer,
    output dct_cnt_t o_dct_count,
    output logic     o_idle
);

    dct_state_t r_state;
    dct_buf_t   r_buf;
    dct_cnt_t   r_cnt;
    logic       r_flush_pending;

    logic       w_sym_ready;
    logic       w_accept;
    dct_buf_t   w_post_buf;
    dct_cnt_t   w_post_cnt;
    logic       w_flush_req;
    logic       w_seal;
    logic       w_slot_free;
    logic       w_load;
    logic       w_word_valid;
    dct_buf_t   w_word_data;
    dct_cnt_t   w_word_count;

    // Ready depends only on reset and registered state, never on sym_valid
    assign w_sym_ready = !i_reset && (r_state != STALL);
    assign w_accept    = dct.sym_valid && w_sym_ready;

    // Accumulator contents as they would be after this cycle's accept
    always_comb begin
        w_post_buf = r_buf;
        w_post_cnt = r_cnt;
        if (w_accept) begin
            w_post_buf = {r_buf[BUF_W-SYMBOL_W-1:0], dct.sym_data};
            w_post_cnt = r_cnt + COUNT_W'(1);
        end
    end

    // A word is ready to seal when full, or when a flush covers a non-empty buffer
    assign w_flush_req = dct.flush || r_flush_pending;
    assign w_seal      = (w_post_cnt == COUNT_W'(SLOTS)) ||
                         (w_flush_req && (w_post_cnt != '0));
    assign w_slot_free = !w_word_valid || dct.word_ready;
    assign w_load      = w_seal && w_slot_free;

    // Accumulator, fill count, pending flush and FSM; a blocked seal parks in STALL
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_buf           <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else if (w_load) begin
            r_state         <= IDLE;
            r_buf           <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_buf           <= w_post_buf;
            r_cnt           <= w_post_cnt;
            // Only a flush that had something to seal is remembered
            r_flush_pending <= w_seal && w_flush_req;
            if (w_seal) begin
                r_state <= STALL;
            end else if (w_post_cnt == '0) begin
                r_state <= IDLE;
            end else begin
                r_state <= ACCUM;
            end
        end
    end

    nios_fprint_dct_out_slot u_out_slot (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_data  (w_post_buf),
        .i_count (w_post_cnt),
        .i_ready (dct.word_ready),
        .o_valid (w_word_valid),
        .o_data  (w_word_data),
        .o_count (w_word_count)
    );

    assign dct.sym_ready  = w_sym_ready;
    assign dct.word_valid = w_word_valid;
    assign dct.word_data  = w_word_data;
    assign dct.word_count = w_word_count;

    assign o_dct_buffer = r_buf;
    assign o_dct_count  = r_cnt;
    assign o_idle       = (r_cnt == '0) && !w_word_valid && !r_flush_pending;

endmodule

// File: tb/tb_nios_fprint_processorm_0_cpu0_dct_packer.sv
// Directed self-checking bench for the DCT packer.
// Latency: n/a.
// Backpressure: word_ready driven explicitly per scenario.
module tb_nios_fprint_processorm_0_cpu0_dct_packer;
    import nios_fprint_dct_pkg::*;

    logic     clk;
    logic     reset;
    dct_buf_t dct_buffer;
    dct_cnt_t dct_count;
    logic     idle;

    int n_vec = 0;
    int n_err = 0;

    nios_fprint_processorm_0_cpu0_dct_packer_if u_if ();

    nios_fprint_processorm_0_cpu0_dct_packer u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .dct          (u_if),
        .o_dct_buffer (dct_buffer),
        .o_dct_count  (dct_count),
        .o_idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] d, input logic fl);
        u_if.sym_valid = 1'b1;
        u_if.sym_data  = d;
        u_if.flush     = fl;
        tick();
        u_if.sym_valid = 1'b0;
        u_if.flush     = 1'b0;
    endtask

    task automatic do_flush();
        u_if.flush = 1'b1;
        tick();
        u_if.flush = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        u_if.sym_valid = 1'b0;
        u_if.sym_data  = '0;
        u_if.flush     = 1'b0;
        u_if.word_ready = 1'b0;
        tick();
        tick();
        chk("rst_word_valid", 32'(u_if.word_valid), 0);
        chk("rst_dct_count",  32'(dct_count), 0);
        chk("rst_sym_ready",  32'(u_if.sym_ready), 0);
        reset = 1'b0;
        #1;
        chk("rel_idle",       32'(idle), 1);
        chk("rel_sym_ready",  32'(u_if.sym_ready), 1);

        // 1) fifteen 2'b01 back-to-back with word_ready high
        u_if.word_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            u_if.sym_valid = 1'b1;
            u_if.sym_data  = 2'b01;
            chk("t1_ready",  32'(u_if.sym_ready), 1);
            chk("t1_count",  32'(dct_count), 32'(i));
            tick();
        end
        u_if.sym_valid = 1'b0;
        chk("t1_wvalid",   32'(u_if.word_valid), 1);
        chk("t1_wdata",    32'(u_if.word_data), 32'h15555555);
        chk("t1_wcount",   32'(u_if.word_count), 15);
        chk("t1_dcount",   32'(dct_count), 0);
        chk("t1_ready_after", 32'(u_if.sym_ready), 1);
        tick();
        chk("t1_drained",  32'(u_if.word_valid), 0);

        // 2) symbols 3,2,1 then flush
        send_sym(2'b11, 1'b0);
        send_sym(2'b10, 1'b0);
        send_sym(2'b01, 1'b0);
        chk("t2_buf",      32'(dct_buffer), 32'h39);
        chk("t2_count",    32'(dct_count), 3);
        do_flush();
        chk("t2_wvalid",   32'(u_if.word_valid), 1);
        chk("t2_wdata",    32'(u_if.word_data), 32'h39);
        chk("t2_wcount",   32'(u_if.word_count), 3);
        chk("t2_dcount",   32'(dct_count), 0);
        chk("t2_idle_busy", 32'(idle), 0);
        tick();
        chk("t2_idle",     32'(idle), 1);

        // 3) held word, 15 x 2'b10 into STALL, then release
        u_if.word_ready = 1'b0;
        send_sym(2'b01, 1'b1);
        chk("t3_held",     32'(u_if.word_data), 32'h1);
        for (int i = 0; i < 15; i++) send_sym(2'b10, 1'b0);
        chk("t3_count",    32'(dct_count), 15);
        chk("t3_stall",    32'(u_if.sym_ready), 0);
        chk("t3_buf",      32'(dct_buffer), 32'h2AAAAAAA);
        tick();
        chk("t3_still_old", 32'(u_if.word_data), 32'h1);
        chk("t3_still_stall", 32'(u_if.sym_ready), 0);
        u_if.word_ready = 1'b1;
        tick();
        chk("t3_refill_v", 32'(u_if.word_valid), 1);
        chk("t3_refill_d", 32'(u_if.word_data), 32'h2AAAAAAA);
        chk("t3_refill_c", 32'(u_if.word_count), 15);
        chk("t3_dcount",   32'(dct_count), 0);
        chk("t3_ready",    32'(u_if.sym_ready), 1);
        tick();
        chk("t3_drained",  32'(u_if.word_valid), 0);
        chk("t3_idle",     32'(idle), 1);

        // 4) flush on empty, then symbol + flush together
        do_flush();
        chk("t4_noword",   32'(u_if.word_valid), 0);
        chk("t4_idle",     32'(idle), 1);
        send_sym(2'b11, 1'b1);
        chk("t4_wvalid",   32'(u_if.word_valid), 1);
        chk("t4_wdata",    32'(u_if.word_data), 32'h3);
        chk("t4_wcount",   32'(u_if.word_count), 1);
        tick();

        // 5) flush with busy slot at count 5, merged second flush
        u_if.word_ready = 1'b0;
        send_sym(2'b10, 1'b1);
        for (int i = 0; i < 5; i++) send_sym(2'b01, 1'b0);
        chk("t5_count",    32'(dct_count), 5);
        do_flush();
        chk("t5_stall",    32'(u_if.sym_ready), 0);
        chk("t5_idle",     32'(idle), 0);
        chk("t5_old",      32'(u_if.word_data), 32'h2);
        do_flush();
        u_if.sym_valid = 1'b1;
        u_if.sym_data  = 2'b11;
        tick();
        chk("t5_noaccept", 32'(dct_count), 5);
        u_if.sym_valid = 1'b0;
        u_if.word_ready = 1'b1;
        tick();
        chk("t5_wvalid",   32'(u_if.word_valid), 1);
        chk("t5_wdata",    32'(u_if.word_data), 32'h155);
        chk("t5_wcount",   32'(u_if.word_count), 5);
        chk("t5_ready",    32'(u_if.sym_ready), 1);
        tick();
        chk("t5_single",   32'(u_if.word_valid), 0);
        chk("t5_idle_end", 32'(idle), 1);

        // 6) reset at count 7 with a held word
        u_if.word_ready = 1'b0;
        send_sym(2'b01, 1'b1);
        for (int i = 0; i < 7; i++) send_sym(2'b11, 1'b0);
        chk("t6_count",    32'(dct_count), 7);
        reset = 1'b1;
        tick();
        chk("t6_wvalid",   32'(u_if.word_valid), 0);
        chk("t6_wdata",    32'(u_if.word_data), 0);
        chk("t6_wcount",   32'(u_if.word_count), 0);
        chk("t6_buf",      32'(dct_buffer), 0);
        chk("t6_dcount",   32'(dct_count), 0);
        chk("t6_ready",    32'(u_if.sym_ready), 0);
        reset = 1'b0;
        #1;
        chk("t6_idle",     32'(idle), 1);
        u_if.word_ready = 1'b1;
        send_sym(2'b10, 1'b0);
        send_sym(2'b01, 1'b1);
        chk("t6_fresh_d",  32'(u_if.word_data), 32'h9);
        chk("t6_fresh_c",  32'(u_if.word_count), 2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
